// File: rtl/lsu_sram.sv
// lsu_sram: single-ported word-addressed SRAM behind a valid/ready
// load/store request channel with a fixed, parameterised response latency.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake (ready only when idle)
//   req_wen                    1 = write, 0 = read
//   req_addr                   32-bit byte address, word 0 at BASE
//   req_wdata / req_wmask      write data and per-byte write enables
//   rsp_valid / rsp_ready      response handshake
//   rsp_rdata                  read data (0 for writes, errors, and when idle)
//   rsp_err                    misaligned or out-of-range access
//
// One request is outstanding at a time. Storage is committed and read data
// captured at the accepting edge; the response is presented LAT cycles later.
module lsu_sram #(
    parameter int          DATA_W     = 32,
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int          LAT        = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [31:0]           req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = (DATA_W == 64) ? 3 : 2;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [3:0]              cnt_r;
    logic [3:0]              cnt_nxt_s;
    logic                    accept_s;
    logic [31:0]             offset_s;
    logic [31:0]             word_idx_s;
    logic                    addr_err_s;
    logic [DEPTH_LOG2-1:0]   idx_s;
    logic [DATA_W-1:0]       acc_data_s;
    logic [DATA_W-1:0]       data_r;
    logic                    err_r;
    logic                    enter_resp_s;
    logic [DATA_W-1:0]       rsp_data_nxt_s;
    logic                    rsp_err_nxt_s;
    logic                    rsp_valid_r;
    logic [DATA_W-1:0]       rsp_rdata_r;
    logic                    rsp_err_r;
    logic [DATA_W-1:0]       mem [DEPTH];

    assign req_ready = (state_r == IDLE);
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

    // Address decode: wrapping offset from BASE, so addresses below BASE land
    // on a huge index and are caught by the range check.
    always_comb begin
        offset_s   = req_addr - BASE;
        word_idx_s = offset_s >> OFF_W;
        idx_s      = word_idx_s[DEPTH_LOG2-1:0];
        addr_err_s = (|req_addr[OFF_W-1:0]) || (|word_idx_s[31:DEPTH_LOG2]);
        // rst_n gate keeps a request seen during reset from touching storage
        accept_s   = req_valid && (state_r == IDLE) && rst_n;
        if (addr_err_s || req_wen) begin
            acc_data_s = {DATA_W{1'b0}};
        end else begin
            acc_data_s = mem[idx_s];
        end
    end

    // Next-state and latency-counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (LAT == 1) begin
                        state_nxt_s = RESP;
                        cnt_nxt_s   = 4'd0;
                    end else begin
                        state_nxt_s = WAIT;
                        cnt_nxt_s   = 4'(LAT - 1);
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                // WAIT lasts LAT-1 cycles; the last decrement reaches 0
                if (cnt_r <= 4'd1) begin
                    state_nxt_s = RESP;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    state_nxt_s = WAIT;
                    cnt_nxt_s   = cnt_r - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Response payload source: straight from the accept path when LAT=1,
    // otherwise from the values captured at acceptance.
    always_comb begin
        enter_resp_s = (state_nxt_s == RESP) && (state_r != RESP);
        if (state_r == IDLE) begin
            rsp_data_nxt_s = acc_data_s;
            rsp_err_nxt_s  = addr_err_s;
        end else begin
            rsp_data_nxt_s = data_r;
            rsp_err_nxt_s  = err_r;
        end
    end

    // State, counter and captured-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            data_r  <= {DATA_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (accept_s) begin
                data_r <= acc_data_s;
                err_r  <= addr_err_s;
            end
        end
    end

    // Registered response outputs; zero whenever no response is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
        end else if (enter_resp_s) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= rsp_data_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
        end else if ((state_r == RESP) && rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
        end
    end

    // Byte-masked storage write; storage deliberately has no reset.
    always_ff @(posedge clk) begin
        if (accept_s && req_wen && !addr_err_s) begin
            for (int b = 0; b < NB; b++) begin
                if (req_wmask[b]) begin
                    mem[idx_s][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_sram.sv
// tb_lsu_sram: directed self-checking bench for lsu_sram.
// Unit 0: DATA_W=32, LAT=2. Unit 1: DATA_W=64, LAT=1. Unit 2: DATA_W=64, LAT=15.
module tb_lsu_sram;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_valid = 3'b000;
    logic [2:0]  req_ready;
    logic [2:0]  req_wen = 3'b000;
    logic [31:0] req_addr [3];
    logic [31:0] wd0 = 32'h0;
    logic [63:0] wd1 = 64'h0;
    logic [63:0] wd2 = 64'h0;
    logic [3:0]  wm0 = 4'h0;
    logic [7:0]  wm1 = 8'h0;
    logic [7:0]  wm2 = 8'h0;
    logic [2:0]  rsp_valid;
    logic [2:0]  rsp_ready = 3'b111;
    logic [31:0] rd0;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [2:0]  rsp_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu_sram #(.DATA_W(32), .DEPTH_LOG2(10), .BASE(32'h8000_0000), .LAT(2)) u0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
        .req_addr(req_addr[0]), .req_wdata(wd0), .req_wmask(wm0),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rd0), .rsp_err(rsp_err[0]));

    lsu_sram #(.DATA_W(64), .DEPTH_LOG2(10), .BASE(32'h8000_0000), .LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
        .req_addr(req_addr[1]), .req_wdata(wd1), .req_wmask(wm1),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rd1), .rsp_err(rsp_err[1]));

    lsu_sram #(.DATA_W(64), .DEPTH_LOG2(10), .BASE(32'h8000_0000), .LAT(15)) u2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_wen(req_wen[2]),
        .req_addr(req_addr[2]), .req_wdata(wd2), .req_wmask(wm2),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rd2), .rsp_err(rsp_err[2]));

    // Single comparison point: counts every vector, reports any miscompare.
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rdata(input int u);
        case (u)
            0:       rdata = {32'h0, rd0};
            1:       rdata = rd1;
            default: rdata = rd2;
        endcase
    endfunction

    task automatic drive(input int u, input logic v, input logic wen,
                         input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
        req_valid[u] = v;
        req_wen[u]   = wen;
        req_addr[u]  = a;
        case (u)
            0:       begin wd0 = d[31:0]; wm0 = m[3:0]; end
            1:       begin wd1 = d;       wm1 = m;      end
            default: begin wd2 = d;       wm2 = m;      end
        endcase
    endtask

    // One request with rsp_ready high; returns data, error and latency in cycles.
    task automatic txn(input int u, input logic wen, input logic [31:0] a,
                       input logic [63:0] d, input logic [7:0] m,
                       output logic [63:0] rd, output logic er, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready[u] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("req_ready_before_req", {63'h0, req_ready[u]}, 64'h1);
        drive(u, 1'b1, wen, a, d, m);
        @(posedge clk);
        #1;
        drive(u, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
        lat = 1;
        while (!rsp_valid[u] && lat < 40) begin
            check_val("quiet_while_waiting", rdata(u) | {63'h0, rsp_err[u]}, 64'h0);
            @(posedge clk);
            #1;
            lat++;
        end
        rd = rdata(u);
        er = rsp_err[u];
        @(posedge clk);
        #1;
    endtask

    task automatic access(input string tag, input int u, input logic wen,
                          input logic [31:0] a, input logic [63:0] d, input logic [7:0] m,
                          input logic [63:0] exp_rd, input logic exp_er, input int exp_lat);
        logic [63:0] rd;
        logic        er;
        int          lat;
        txn(u, wen, a, d, m, rd, er, lat);
        check_val({tag, "_rdata"}, rd, exp_rd);
        check_val({tag, "_err"}, {63'h0, er}, {63'h0, exp_er});
        check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        for (int i = 0; i < 3; i++) req_addr[i] = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_rsp_valid", {61'h0, rsp_valid}, 64'h0);
        check_val("rst_rsp_err", {61'h0, rsp_err}, 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_req_ready", {61'h0, req_ready}, 64'h7);
        check_val("rst_rsp_valid_after", {61'h0, rsp_valid}, 64'h0);
        check_val("rst_rdata0", rdata(0), 64'h0);
        check_val("rst_rdata2", rdata(2), 64'h0);

        // Unit 0 (32-bit, LAT=2): full write and readback
        access("w_deadbeef", 0, 1'b1, 32'h8000_0010, 64'hDEAD_BEEF, 8'hF, 64'h0, 1'b0, 2);
        access("r_deadbeef", 0, 1'b0, 32'h8000_0010, 64'h0, 8'h0, 64'hDEAD_BEEF, 1'b0, 2);
        // Partial write of lane 1
        access("w_base", 0, 1'b1, 32'h8000_0020, 64'h1122_3344, 8'hF, 64'h0, 1'b0, 2);
        access("w_lane1", 0, 1'b1, 32'h8000_0020, 64'h0000_AA00, 8'h2, 64'h0, 1'b0, 2);
        access("r_lane1", 0, 1'b0, 32'h8000_0020, 64'h0, 8'h0, 64'h1122_AA44, 1'b0, 2);
        // Zero mask writes nothing but still responds
        access("w_mask0", 0, 1'b1, 32'h8000_0020, 64'hFFFF_FFFF, 8'h0, 64'h0, 1'b0, 2);
        access("r_mask0", 0, 1'b0, 32'h8000_0020, 64'h0, 8'h0, 64'h1122_AA44, 1'b0, 2);
        // Errors: misaligned, below BASE, past the top
        access("r_misalign", 0, 1'b0, 32'h8000_0002, 64'h0, 8'h0, 64'h0, 1'b1, 2);
        access("r_below", 0, 1'b0, 32'h7FFF_FFFC, 64'h0, 8'h0, 64'h0, 1'b1, 2);
        access("w_top", 0, 1'b1, 32'h8000_0FFC, 64'h5A5A_0FFC, 8'hF, 64'h0, 1'b0, 2);
        access("r_top", 0, 1'b0, 32'h8000_0FFC, 64'h0, 8'h0, 64'h5A5A_0FFC, 1'b0, 2);
        access("r_past_top", 0, 1'b0, 32'h8000_1000, 64'h0, 8'h0, 64'h0, 1'b1, 2);
        // Error writes must leave storage untouched (0x7FFFFFF0 aliases word 1020)
        access("w_word1020", 0, 1'b1, 32'h8000_0FF0, 64'h0BAD_F00D, 8'hF, 64'h0, 1'b0, 2);
        access("w_err_below", 0, 1'b1, 32'h7FFF_FFF0, 64'hFFFF_FFFF, 8'hF, 64'h0, 1'b1, 2);
        access("r_word1020", 0, 1'b0, 32'h8000_0FF0, 64'h0, 8'h0, 64'h0BAD_F00D, 1'b0, 2);
        access("w_err_mis", 0, 1'b1, 32'h8000_0012, 64'h0, 8'hF, 64'h0, 1'b1, 2);
        access("r_after_err", 0, 1'b0, 32'h8000_0010, 64'h0, 8'h0, 64'hDEAD_BEEF, 1'b0, 2);

        // Backpressure: response held, extra request ignored until handshake
        rsp_ready[0] = 1'b0;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h8000_0020, 64'h0, 8'h0);
        @(posedge clk);
        #1;
        req_addr[0] = 32'h8000_0010;
        @(posedge clk);
        #1;
        check_val("bp_valid_rise", {63'h0, rsp_valid[0]}, 64'h1);
        for (int i = 0; i < 5; i++) begin
            check_val("bp_req_ready", {63'h0, req_ready[0]}, 64'h0);
            check_val("bp_rdata", rdata(0), 64'h1122_AA44);
            check_val("bp_valid_hold", {63'h0, rsp_valid[0]}, 64'h1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        check_val("bp_after_hs_valid", {63'h0, rsp_valid[0]}, 64'h0);
        check_val("bp_after_hs_ready", {63'h0, req_ready[0]}, 64'h1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
        check_val("bp_second_accepted", {63'h0, req_ready[0]}, 64'h0);
        @(posedge clk);
        #1;
        check_val("bp_second_valid", {63'h0, rsp_valid[0]}, 64'h1);
        check_val("bp_second_rdata", rdata(0), 64'hDEAD_BEEF);
        @(posedge clk);
        #1;

        // Reset one cycle after accepting a read (response already up)
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h8000_0010, 64'h0, 8'h0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
        @(posedge clk);
        #1;
        check_val("mid_valid_before_rst", {63'h0, rsp_valid[0]}, 64'h1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", {63'h0, rsp_valid[0]}, 64'h0);
        check_val("mid_rst_rdata", rdata(0), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("post_rst_ready", {63'h0, req_ready[0]}, 64'h1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid[0]) seen++;
            @(posedge clk);
            #1;
        end
        check_val("no_rsp_after_rst", 64'(seen), 64'h0);
        access("r_kept_over_rst", 0, 1'b0, 32'h8000_0010, 64'h0, 8'h0, 64'hDEAD_BEEF, 1'b0, 2);

        // Unit 1 (64-bit, LAT=1)
        access("u1_w", 1, 1'b1, 32'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 1'b0, 1);
        access("u1_w_lanes", 1, 1'b1, 32'h8000_0008, 64'hAA00_0000_0000_00BB, 8'h81, 64'h0, 1'b0, 1);
        access("u1_r", 1, 1'b0, 32'h8000_0008, 64'h0, 8'h0, 64'hAA22_3344_5566_77BB, 1'b0, 1);
        access("u1_misalign", 1, 1'b0, 32'h8000_0004, 64'h0, 8'h0, 64'h0, 1'b1, 1);

        // Unit 2 (64-bit, LAT=15)
        access("u2_w", 2, 1'b1, 32'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 1'b0, 15);
        access("u2_w_low", 2, 1'b1, 32'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0, 1'b0, 15);
        access("u2_r", 2, 1'b0, 32'h8000_0008, 64'h0, 8'h0, 64'h1122_3344_FFFF_FFFF, 1'b0, 15);
        access("u2_below", 2, 1'b0, 32'h7FFF_FFF8, 64'h0, 8'h0, 64'h0, 1'b1, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_sram.md
LSU_SRAM -- requirements
Module: lsu_sram

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter DEPTH_LOG2, default 10: log2 of storage depth in DATA_W-bit words.
REQ-003 SHALL have parameter BASE, default 32'h8000_0000: byte address of word 0.
REQ-004 SHALL have parameter LAT, default 2: request-to-response latency in cycles; legal range 1..15.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, 1: request present.
REQ-008 SHALL have port req_ready, output, 1: block accepts a request this cycle.
REQ-009 SHALL have port req_wen, input, 1: 1=write, 0=read.
REQ-010 SHALL have port req_addr, input, 32: byte address.
REQ-011 SHALL have port req_wdata, input, DATA_W: write data.
REQ-012 SHALL have port req_wmask, input, DATA_W/8: byte-lane write enable, bit i for byte i.
REQ-013 SHALL have port rsp_valid, output, 1: response present.
REQ-014 SHALL have port rsp_ready, input, 1: consumer accepts response.
REQ-015 SHALL have port rsp_rdata, output, DATA_W: read data; 0 for writes and errors.
REQ-016 SHALL have port rsp_err, output, 1: access faulted.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP; req_ready=1 only in IDLE, rsp_valid=1 only in RESP.
REQ-018 SHALL accept a request on a rising edge where req_valid && req_ready, then move IDLE->WAIT (LAT>1) or IDLE->RESP (LAT=1).
REQ-019 SHALL hold a down-counter loaded with LAT-1 on acceptance, decrement once per cycle in WAIT, and enter RESP when it reaches 0, so rsp_valid first rises exactly LAT cycles after the accepting edge.
REQ-020 SHALL compute word index = (req_addr - BASE) >> log2(DATA_W/8), with 32-bit wrapping subtraction.
REQ-021 SHALL flag an error when req_addr has any nonzero low log2(DATA_W/8) bits, or index >= 2^DEPTH_LOG2, including addresses below BASE that wrap to a large index.
REQ-022 SHALL, on accepting a non-error write, update exactly the bytes selected by req_wmask at that edge; unselected bytes are unchanged; wmask=0 writes nothing but still responds.
REQ-023 SHALL, on accepting a non-error read, capture the word at that edge into a response register; a later write does not alter the captured data.
REQ-024 SHALL, on error, perform no storage update, and return rsp_err=1 with rsp_rdata=0 after the normal LAT.
REQ-025 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_valid && rsp_ready, then move to IDLE at that edge.
REQ-026 SHALL ignore req_valid while not in IDLE; those requests are not accepted or queued.
REQ-027 SHALL sustain at most one outstanding request; back-to-back throughput is one request per LAT+1 cycles when rsp_ready is held high.
REQ-028 SHALL keep rsp_rdata and rsp_err at 0 whenever rsp_valid=0.

Reset
REQ-029 SHALL, while rst_n=0, force state IDLE, counter 0, req_ready=1 after reset release, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-030 SHALL leave storage contents unchanged by reset; a write accepted before reset assertion remains committed.
REQ-031 SHALL abandon any in-flight response when reset asserts mid-WAIT or mid-RESP; no response is produced for it after release.

Verification
REQ-032 Write 0xDEADBEEF to 0x8000_0010 with wmask 4'hF, then read it back with LAT=2 -> read rsp_valid rises 2 cycles after acceptance, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-033 Partial write 0x0000_AA00 with wmask 4'b0010 over 0x1122_3344 -> readback 0x1122_AA44.
REQ-034 Read 0x8000_0002 (misaligned) and 0x7FFF_FFFC (below BASE) -> each gives rsp_err=1, rsp_rdata=0 after LAT; storage unchanged.
REQ-035 Hold rsp_ready=0 for 5 cycles in RESP while driving req_valid=1 -> req_ready stays 0, response stable, second request accepted only in the cycle after the response handshake.
REQ-036 Assert rst_n=0 one cycle after accepting a read -> rsp_valid=0 immediately, stays 0 after release, req_ready=1 on the first cycle after release.
REQ-037 Sweep LAT=1 and LAT=15 with DATA_W=64 -> response latency exactly 1 and 15 cycles, 8-bit wmask honoured.
